// File: rtl/freq_pkg.sv
// Shared widths, state encoding and saturating-accumulator helper for the
// gated frequency counter.
package freq_pkg;

    localparam int                   COUNT_W   = 8;
    localparam logic [COUNT_W-1:0]   COUNT_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    typedef struct packed {
        logic [COUNT_W-1:0] cnt;
        logic               sat;
    } acc_t;

    // A rise arriving at full scale leaves cnt pinned and latches sat.
    function automatic acc_t acc_add(acc_t a, logic inc);
        acc_t r;
        r = a;
        if (inc) begin
            if (a.cnt == COUNT_MAX)
                r.sat = 1'b1;
            else
                r.cnt = a.cnt + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus history flop; rise is a one-cycle strobe
// two clocks after the input is first sampled high.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s1, s2, s3;

    // Cleared history means an input already high at reset release counts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts sig_in rising edges over fixed GATE_CYCLES windows while en is high,
// publishing each completed window's (saturated) count on bin with a valid strobe.
module freq_gate_counter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] bin,
    output logic               valid,
    output logic               overflow
);

    localparam int              TW   = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]   LAST = TW'(GATE_CYCLES - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    acc_t            acc;
    acc_t            acc_nxt;
    logic            rise;
    logic            terminal;

    sync_rise_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .rise  (rise)
    );

    // acc_nxt folds in this cycle's rise so a terminal-cycle edge lands in the closing window.
    assign acc_nxt  = acc_add(acc, rise);
    assign terminal = (timer == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            acc      <= '0;
            bin      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    acc   <= '0;
                    if (en)
                        state <= GATE;
                end
                GATE: begin
                    if (!en) begin
                        state <= IDLE;
                        timer <= '0;
                        acc   <= '0;
                    end else if (terminal) begin
                        // Next window starts on the very next cycle, no dead time.
                        bin      <= acc_nxt.cnt;
                        overflow <= acc_nxt.sat;
                        valid    <= 1'b1;
                        timer    <= '0;
                        acc      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                        acc   <= acc_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    acc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench: stimulus queues expected window results, a negedge
// monitor pops one per valid strobe and checks value and arrival edge.
module tb_freq_gate_counter;

    typedef struct {
        logic [7:0] bin;
        logic       ovf;
        int         at_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sig_in;
    logic [7:0] bin;
    logic       valid;
    logic       overflow;

    int   per = 0;
    int   ph = 0;
    logic man = 1'b0;
    int   edge_n = 0;
    logic rst_q = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] last_bin = 8'd0;
    logic       last_ovf = 1'b0;
    exp_t q[$];

    freq_gate_counter #(.GATE_CYCLES(1000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sig_in   (sig_in),
        .bin      (bin),
        .valid    (valid),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // per==0 selects the manual level, otherwise a free-running square wave.
    assign sig_in = (per == 0) ? man : (ph < per / 2);

    always @(posedge clk) begin
        edge_n++;
        rst_q <= rst_n;
    end

    always begin
        @(posedge clk);
        #1;
        ph = (per == 0) ? 0 : ((ph + 1) % per);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at edge %0d", name, act, req, edge_n);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_q) begin
            chk("reset_bin", bin, 0);
            chk("reset_ovf", overflow, 0);
            chk("reset_valid", valid, 0);
            last_bin = 8'd0;
            last_ovf = 1'b0;
        end else if (valid === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid with bin=%0d at edge %0d, required no valid", bin, edge_n);
            end else begin
                e = q.pop_front();
                chk("bin", bin, e.bin);
                chk("overflow", overflow, e.ovf);
                chk("valid_edge", edge_n, e.at_edge);
                last_bin = e.bin;
                last_ovf = e.ovf;
            end
        end else begin
            chk("valid_low", valid, 0);
            chk("hold_bin", bin, last_bin);
            chk("hold_ovf", overflow, last_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int t);
        while (edge_n < t) step();
    endtask

    task automatic pulse();
        man = 1'b1;
        step();
        man = 1'b0;
    endtask

    task automatic expect_win(logic [7:0] b, logic o, int at);
        exp_t e;
        e.bin = b;
        e.ovf = o;
        e.at_edge = at;
        q.push_back(e);
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d windows pending after %0d cycles, required 0", q.size(), budget);
            q.delete();
        end
    endtask

    initial begin
        int e0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // Period 10: three back-to-back windows of exactly 100 edges.
        per = 10;
        repeat (10) step();
        en = 1'b1;
        e0 = edge_n + 1;
        for (int k = 1; k <= 3; k++) expect_win(8'd100, 1'b0, e0 + 1000 * k);
        drain(3100);
        en = 1'b0;

        // Period 4 then period 2 (saturates).
        per = 4;
        repeat (10) step();
        en = 1'b1;
        e0 = edge_n + 1;
        expect_win(8'd250, 1'b0, e0 + 1000);
        drain(1100);
        en = 1'b0;
        per = 2;
        repeat (10) step();
        en = 1'b1;
        e0 = edge_n + 1;
        expect_win(8'd255, 1'b1, e0 + 1000);
        drain(1100);
        en = 1'b0;

        // Quiet input: zero count, overflow clears.
        per = 0;
        man = 1'b0;
        repeat (10) step();
        en = 1'b1;
        e0 = edge_n + 1;
        expect_win(8'd0, 1'b0, e0 + 1000);
        drain(1100);
        en = 1'b0;

        // en dropped at timer 500, re-armed 20 cycles later.
        per = 10;
        repeat (10) step();
        en = 1'b1;
        e0 = edge_n + 1;
        wait_until(e0 + 500);
        en = 1'b0;
        repeat (20) step();
        en = 1'b1;
        e0 = edge_n + 1;
        expect_win(8'd100, 1'b0, e0 + 1000);
        drain(1100);
        en = 1'b0;

        // Reset at timer 700 aborts the window; then 7 pulses in a fresh one.
        per = 0;
        man = 1'b0;
        repeat (5) step();
        en = 1'b1;
        e0 = edge_n + 1;
        for (int i = 0; i < 3; i++) begin
            wait_until(e0 + 100 + 100 * i);
            pulse();
        end
        wait_until(e0 + 700);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        e0 = edge_n + 1;
        expect_win(8'd7, 1'b0, e0 + 1000);
        for (int i = 0; i < 7; i++) begin
            wait_until(e0 + 50 + 100 * i);
            pulse();
        end
        drain(1100);
        en = 1'b0;

        // Edges at the window boundary: terminal-2 sample closes, terminal-1 spills over.
        repeat (5) step();
        en = 1'b1;
        e0 = edge_n + 1;
        expect_win(8'd1, 1'b0, e0 + 1000);
        expect_win(8'd0, 1'b0, e0 + 2000);
        expect_win(8'd1, 1'b0, e0 + 3000);
        wait_until(e0 + 997);
        pulse();
        wait_until(e0 + 1998);
        pulse();
        drain(3100);
        en = 1'b0;

        repeat (5) step();
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_gate_counter.md
FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000, meaning clk cycles per measurement window (1 s at 1 kHz clk); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; the single clock domain.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port en  input  1  measurement enable; level-sensitive, synchronous to clk.
REQ-005 SHALL have port sig_in  input  1  measured signal; asynchronous to clk.
REQ-006 SHALL have port bin  output  8  last completed window's rising-edge count, unsigned binary; feeds bin_bcd.bin.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when bin is updated.
REQ-008 SHALL have port overflow  output  1  set when the last completed window's count saturated at 255.

Function
REQ-009 SHALL pass sig_in through a two-flop synchronizer (s1, s2), then a history flop (s3); rise = s2 & ~s3.
REQ-010 SHALL count a sig_in rising edge sampled high at clock edge k at clock edge k+2 (fixed 2-cycle detect latency).
REQ-011 SHALL implement states IDLE and GATE; IDLE->GATE at the first clock edge with en=1; GATE->IDLE at any clock edge with en=0.
REQ-012 SHALL hold the window timer and edge accumulator at 0 in IDLE; edges arriving in IDLE are ignored.
REQ-013 SHALL increment the window timer every cycle in GATE, from 0 to GATE_CYCLES-1.
REQ-014 SHALL increment the 8-bit accumulator on each rise in GATE, saturating at 255; a sticky sat flag is set when an increment is attempted at 255.
REQ-015 SHALL, at the clock edge where the timer equals GATE_CYCLES-1: load bin with accumulator plus that cycle's rise (saturated), load overflow with the resulting sat state, pulse valid for exactly one cycle, and clear timer, accumulator and sat.
REQ-016 SHALL start the next window immediately (timer 0 on the following cycle, no dead cycles), so back-to-back windows tile time exactly.
REQ-017 SHALL, on en falling mid-window, discard the partial count; bin and overflow keep their last values and valid stays 0.
REQ-018 SHALL start a fresh full window with timer 0 when en is re-asserted.
REQ-019 SHALL hold bin and overflow stable between valid pulses.
REQ-020 SHALL count an edge coinciding with the terminal cycle in the closing window, never in the next.

Reset
REQ-021 SHALL on rst_n=0 at a clock edge set state IDLE, timer 0, accumulator 0, sat 0, bin 8'd0, valid 0, overflow 0.
REQ-022 SHALL preset s1, s2 and s3 to 0 on reset, so a sig_in already high at reset release counts as one rising edge.
REQ-023 SHALL abort any in-progress window on reset, with no valid pulse.

Structure
REQ-024 SHALL place COUNT_W=8, COUNT_MAX=8'd255 and the state enum (IDLE, GATE) in shared package freq_pkg.
REQ-025 SHALL implement the synchronizer and edge detect as sub-module sync_rise_det (ports clk, rst_n, d, rise).
REQ-026 SHALL size the timer to $clog2(GATE_CYCLES) bits.

Verification (GATE_CYCLES=1000)
REQ-027 SHALL check: en=1, sig_in square wave with period 10 clk -> valid every 1000 cycles, bin=100, overflow=0.
REQ-028 SHALL check: period 4 clk -> bin=250, overflow=0; then period 2 clk -> bin=255, overflow=1 on the next window.
REQ-029 SHALL check: sig_in constant 0 for one window -> bin=0, valid pulses, overflow=0.
REQ-030 SHALL check: en dropped at timer=500 and re-asserted 20 cycles later -> no valid for the partial window, next valid exactly 1000 cycles after re-assertion, bin correct.
REQ-031 SHALL check: rst_n=0 for 2 cycles at timer=700 -> bin=0, overflow=0, valid=0; first valid arrives 1000 cycles after GATE entry.
REQ-032 SHALL check: single sig_in pulse aligned to the terminal cycle minus 2 -> counted in the closing window (bin=1), next window bin=0.
